// File: rtl/xadc_drp_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : xadc_pkg                                                   |
// | Shared FSM encoding, DRP address map and sample pair type.           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package xadc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_A    = 3'd1,
    ST_RD_B    = 3'd2,
    ST_PUBLISH = 3'd3,
    ST_CFG     = 3'd4
  } state_t;

  localparam logic [6:0] c_addr_vaux4 = 7'h14;
  localparam logic [6:0] c_addr_vaux5 = 7'h15;

  // XADC configuration registers 0..2
  localparam logic [6:0] c_addr_cfg0  = 7'h40;
  localparam logic [6:0] c_addr_cfg1  = 7'h41;
  localparam logic [6:0] c_addr_cfg2  = 7'h42;

  localparam int c_code_w = 12;

  typedef logic [1:0][c_code_w-1:0] sample_pair_t;

endpackage
`default_nettype wire

// File: rtl/xadc_drp_scheduler_drp_timeout_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : drp_timeout_counter                                        |
// | 8-bit DRP wait counter, zeroed on the den cycle, flags TIMEOUT-1.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module drp_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] c_last = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  // clear is asserted on the edge that launches den, so the den cycle reads 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign expired = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/xadc_drp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : xadc_drp_scheduler                                         |
// | Shares the XADC DRP between end-of-sequence sample fetch and host.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module xadc_drp_scheduler
  import xadc_pkg::*;
#(
  parameter logic [6:0] ADDR_A  = c_addr_vaux4,
  parameter logic [6:0] ADDR_B  = c_addr_vaux5,
  parameter int         TIMEOUT = 64,
  parameter int         CODE_W  = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   eos,
  output logic                   drp_den,
  output logic                   drp_dwe,
  output logic [6:0]             drp_daddr,
  output logic [15:0]            drp_di,
  input  logic [15:0]            drp_do,
  input  logic                   drp_drdy,
  input  logic                   cfg_req,
  input  logic                   cfg_we,
  input  logic [6:0]             cfg_addr,
  input  logic [15:0]            cfg_wdata,
  output logic                   cfg_ack,
  output logic                   cfg_err,
  output logic [15:0]            cfg_rdata,
  output logic [1:0][CODE_W-1:0] samples,
  output logic                   sample_valid,
  output logic                   timeout_err,
  output logic                   overrun
);

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_pending;
  logic [CODE_W-1:0]        r_shadow_a;
  logic [1:0][CODE_W-1:0]   r_samples;
  logic                     r_den;
  logic                     r_dwe;
  logic [6:0]               r_daddr;
  logic [15:0]              r_di;
  logic                     r_overrun;

  logic                     w_access;
  logic                     w_rdy;
  logic                     w_expired;
  logic                     w_timeout;
  logic                     w_launch;
  logic                     w_eos_drop;
  logic [CODE_W-1:0]        w_code;

  assign w_code   = drp_do[15 -: CODE_W];
  assign w_access = (r_state == ST_RD_A) || (r_state == ST_RD_B) || (r_state == ST_CFG);
  // a stale drdy coinciding with a fresh den belongs to the previous access
  assign w_rdy     = w_access && !r_den && drp_drdy;
  assign w_timeout = w_access && !w_rdy && w_expired;
  assign w_launch  = (w_next != r_state) &&
                     ((w_next == ST_RD_A) || (w_next == ST_RD_B) || (w_next == ST_CFG));
  assign w_eos_drop = eos && (r_pending || (r_state == ST_PUBLISH));

  drp_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_launch),
    .enable  (w_access),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cfg_ack   = 1'b0;
    cfg_err   = 1'b0;
    cfg_rdata = '0;
    case (r_state)
      ST_IDLE: begin
        // an eos in flight outranks the host even before pending is visible
        if (r_pending) begin
          w_next = ST_RD_A;
        end else if (cfg_req && !eos) begin
          w_next = ST_CFG;
        end
      end
      ST_RD_A: begin
        if (w_rdy) begin
          w_next = ST_RD_B;
        end else if (w_timeout) begin
          w_next = ST_IDLE;
        end
      end
      ST_RD_B: begin
        if (w_rdy) begin
          w_next = ST_PUBLISH;
        end else if (w_timeout) begin
          w_next = ST_IDLE;
        end
      end
      ST_PUBLISH: begin
        w_next = ST_IDLE;
      end
      ST_CFG: begin
        if (w_rdy || w_timeout) begin
          w_next  = ST_IDLE;
          cfg_ack = 1'b1;
          cfg_err = w_timeout;
          if (w_rdy && !cfg_we) begin
            cfg_rdata = drp_do;
          end
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_den   <= 1'b0;
      r_dwe   <= 1'b0;
      r_daddr <= '0;
      r_di    <= '0;
    end else begin
      r_den   <= w_launch;
      r_dwe   <= 1'b0;
      r_daddr <= '0;
      r_di    <= '0;
      if (w_launch) begin
        if (w_next == ST_RD_A) begin
          r_daddr <= ADDR_A;
        end else if (w_next == ST_RD_B) begin
          r_daddr <= ADDR_B;
        end else begin
          r_dwe   <= cfg_we;
          r_daddr <= cfg_addr;
          r_di    <= cfg_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_eos_drop;
      if (eos && !w_eos_drop) begin
        r_pending <= 1'b1;
      end else if ((r_state == ST_IDLE) && (w_next == ST_RD_A)) begin
        r_pending <= 1'b0;
      end
    end
  end

  // both codes land on the edge into PUBLISH so the pair is visible with sample_valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow_a <= '0;
      r_samples  <= '0;
    end else begin
      if ((r_state == ST_RD_A) && w_rdy) begin
        r_shadow_a <= w_code;
      end
      if ((r_state == ST_RD_B) && w_rdy) begin
        r_samples <= {w_code, r_shadow_a};
      end
    end
  end

  assign drp_den      = r_den;
  assign drp_dwe      = r_dwe;
  assign drp_daddr    = r_daddr;
  assign drp_di       = r_di;
  assign samples      = r_samples;
  assign sample_valid = (r_state == ST_PUBLISH);
  assign timeout_err  = w_timeout;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_xadc_drp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_xadc_drp_scheduler                                      |
// | Scoreboard bench: directed stimulus, queued expectations, monitor.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_xadc_drp_scheduler;

  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             eos;
  logic             drp_den;
  logic             drp_dwe;
  logic [6:0]       drp_daddr;
  logic [15:0]      drp_di;
  logic [15:0]      drp_do;
  logic             drp_drdy;
  logic             cfg_req;
  logic             cfg_we;
  logic [6:0]       cfg_addr;
  logic [15:0]      cfg_wdata;
  logic             cfg_ack;
  logic             cfg_err;
  logic [15:0]      cfg_rdata;
  logic [1:0][11:0] samples;
  logic             sample_valid;
  logic             timeout_err;
  logic             overrun;

  xadc_drp_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .eos          (eos),
    .drp_den      (drp_den),
    .drp_dwe      (drp_dwe),
    .drp_daddr    (drp_daddr),
    .drp_di       (drp_di),
    .drp_do       (drp_do),
    .drp_drdy     (drp_drdy),
    .cfg_req      (cfg_req),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_ack      (cfg_ack),
    .cfg_err      (cfg_err),
    .cfg_rdata    (cfg_rdata),
    .samples      (samples),
    .sample_valid (sample_valid),
    .timeout_err  (timeout_err),
    .overrun      (overrun)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic dwe; logic [6:0] addr; logic [15:0] di; } den_exp_t;
  typedef struct { logic [11:0] a; logic [11:0] b; int cyc; } sv_exp_t;
  typedef struct { logic err; logic [15:0] rdata; } cfg_exp_t;
  typedef struct { int delay; logic [15:0] data; } rsp_t;  // delay < 0 withholds drdy

  den_exp_t den_q[$];
  sv_exp_t  sv_q[$];
  cfg_exp_t cfg_q[$];
  rsp_t     rsp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_sv = 0, n_ack = 0, n_to = 0, n_ov = 0;
  int den_cyc = 0, sv_cyc = 0, ack_cyc = 0, to_cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks = checks + 1;
    failures = failures + 1;
    $display("FAIL %s", name);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_outs"}, {drp_den, drp_dwe, drp_daddr, drp_di, cfg_ack, cfg_err,
                            cfg_rdata, sample_valid, timeout_err, overrun}, 64'd0);
    check({name, "_samples"}, samples, 64'd0);
  endtask

  function automatic int evt_cnt(input int which);
    case (which)
      0:       return n_sv;
      1:       return n_ack;
      default: return n_to;
    endcase
  endfunction

  task automatic wait_evt(input int which, input int target, input string name);
    int n;
    n = 0;
    while (evt_cnt(which) < target && n < 300) begin
      @(negedge clk);
      #2;
      n = n + 1;
    end
    if (evt_cnt(which) < target) fail_evt({name, " wait expired"});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_start(input logic we, input logic [6:0] a, input logic [15:0] d);
    cfg_we    = we;
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_req   = 1'b1;
  endtask

  task automatic host_finish(input int target, input string name);
    wait_evt(1, target, name);
    @(posedge clk);
    #1;
    cfg_req = 1'b0;
  endtask

  // DRP slave model: answers each den from the response queue
  initial begin : responder
    rsp_t r;
    drp_drdy = 1'b0;
    drp_do   = '0;
    forever begin
      @(negedge clk);
      if (drp_den && !reset && rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        if (r.delay > 0) begin
          repeat (r.delay) @(posedge clk);
          #1;
          drp_drdy = 1'b1;
          drp_do   = r.data;
          @(posedge clk);
          #1;
          drp_drdy = 1'b0;
          drp_do   = '0;
        end
      end
    end
  end

  initial begin : monitor
    den_exp_t de;
    sv_exp_t  se;
    cfg_exp_t ce;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (drp_den) begin
          den_cyc = cyc;
          if (den_q.size() == 0) fail_evt("unexpected_den");
          else begin
            de = den_q.pop_front();
            check("den_addr", drp_daddr, de.addr);
            check("den_dwe", drp_dwe, de.dwe);
            check("den_di", drp_di, de.di);
          end
        end
        if (sample_valid) begin
          n_sv = n_sv + 1;
          sv_cyc = cyc;
          if (sv_q.size() == 0) fail_evt("unexpected_sample_valid");
          else begin
            se = sv_q.pop_front();
            check("samples_a", samples[0], se.a);
            check("samples_b", samples[1], se.b);
            if (se.cyc >= 0) check("sample_latency", cyc, se.cyc);
          end
        end
        if (cfg_ack) begin
          n_ack = n_ack + 1;
          ack_cyc = cyc;
          if (cfg_q.size() == 0) fail_evt("unexpected_cfg_ack");
          else begin
            ce = cfg_q.pop_front();
            check("cfg_err", cfg_err, ce.err);
            check("cfg_rdata", cfg_rdata, ce.rdata);
          end
        end
        if (timeout_err) begin
          n_to = n_to + 1;
          to_cyc = cyc;
        end
        if (overrun) n_ov = n_ov + 1;
      end
    end
  end

  initial begin : stimulus
    int e_cyc;
    reset = 1'b1; eos = 1'b0; cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    tick(3);
    check_quiet("reset");
    reset = 1'b0;
    tick(2);
    check_quiet("post_reset");

    // basic fetch, drdy 3 cycles after each den
    e_cyc = cyc;
    den_q.push_back('{1'b0, 7'h14, 16'h0});
    den_q.push_back('{1'b0, 7'h15, 16'h0});
    rsp_q.push_back('{3, 16'hABC0});
    rsp_q.push_back('{3, 16'h1230});
    sv_q.push_back('{12'hABC, 12'h123, e_cyc + 10});
    eos = 1'b1; tick(1); eos = 1'b0;
    wait_evt(0, 1, "fetch1");
    tick(3);
    check("fetch1_sv_count", n_sv, 1);
    check("fetch1_no_overrun", n_ov, 0);
    check("fetch1_samples_hold", samples, {12'h123, 12'hABC});

    // host read then host write (write must return rdata 0)
    den_q.push_back('{1'b0, 7'h41, 16'h0});
    rsp_q.push_back('{3, 16'h2000});
    cfg_q.push_back('{1'b0, 16'h2000});
    host_start(1'b0, 7'h41, 16'h0);
    host_finish(1, "cfg_read");
    tick(2);
    den_q.push_back('{1'b1, 7'h40, 16'h1234});
    rsp_q.push_back('{2, 16'hFFFF});
    cfg_q.push_back('{1'b0, 16'h0000});
    host_start(1'b1, 7'h40, 16'h1234);
    host_finish(2, "cfg_write");
    tick(2);

    // eos and cfg_req in the same cycle: fetch wins
    e_cyc = cyc;
    den_q.push_back('{1'b0, 7'h14, 16'h0});
    den_q.push_back('{1'b0, 7'h15, 16'h0});
    den_q.push_back('{1'b0, 7'h42, 16'h0});
    rsp_q.push_back('{2, 16'h5550});
    rsp_q.push_back('{2, 16'h6660});
    rsp_q.push_back('{2, 16'hBEEF});
    sv_q.push_back('{12'h555, 12'h666, e_cyc + 8});
    cfg_q.push_back('{1'b0, 16'hBEEF});
    eos = 1'b1;
    host_start(1'b0, 7'h42, 16'h0);
    tick(1);
    eos = 1'b0;
    host_finish(3, "collide");
    check("collide_order", (sv_cyc < ack_cyc), 1);
    tick(2);

    // drdy withheld in RD_B: timeout, no publish, samples hold
    den_q.push_back('{1'b0, 7'h14, 16'h0});
    den_q.push_back('{1'b0, 7'h15, 16'h0});
    rsp_q.push_back('{3, 16'h7770});
    rsp_q.push_back('{-1, 16'h0});
    eos = 1'b1; tick(1); eos = 1'b0;
    wait_evt(2, 1, "rdb_timeout");
    check("rdb_timeout_latency", to_cyc - den_cyc, TIMEOUT - 1);
    tick(3);
    check("rdb_timeout_no_sv", n_sv, 2);
    check("rdb_timeout_samples", samples, {12'h666, 12'h555});
    e_cyc = cyc;
    den_q.push_back('{1'b0, 7'h14, 16'h0});
    den_q.push_back('{1'b0, 7'h15, 16'h0});
    rsp_q.push_back('{1, 16'h1110});
    rsp_q.push_back('{1, 16'h2220});
    sv_q.push_back('{12'h111, 12'h222, e_cyc + 6});
    eos = 1'b1; tick(1); eos = 1'b0;
    wait_evt(0, 3, "refetch");
    tick(2);

    // two eos 2 cycles apart, then a third while pending
    for (int i = 0; i < 2; i++) begin
      den_q.push_back('{1'b0, 7'h14, 16'h0});
      den_q.push_back('{1'b0, 7'h15, 16'h0});
    end
    rsp_q.push_back('{6, 16'h1010});
    rsp_q.push_back('{6, 16'h2020});
    rsp_q.push_back('{6, 16'h3030});
    rsp_q.push_back('{6, 16'h4040});
    sv_q.push_back('{12'h101, 12'h202, -1});
    sv_q.push_back('{12'h303, 12'h404, -1});
    eos = 1'b1; tick(1); eos = 1'b0; tick(1);
    eos = 1'b1; tick(1); eos = 1'b0; tick(1);
    check("double_eos_no_overrun", n_ov, 0);
    eos = 1'b1; tick(1); eos = 1'b0;
    wait_evt(0, 5, "double_eos");
    tick(3);
    check("triple_eos_overrun", n_ov, 1);
    check("double_eos_sv_count", n_sv, 5);

    // host access timeout
    den_q.push_back('{1'b0, 7'h41, 16'h0});
    rsp_q.push_back('{-1, 16'h0});
    cfg_q.push_back('{1'b1, 16'h0});
    host_start(1'b0, 7'h41, 16'h0);
    host_finish(4, "cfg_timeout");
    check("cfg_timeout_latency", to_cyc - den_cyc, TIMEOUT - 1);
    check("cfg_timeout_count", n_to, 2);
    tick(2);

    // asynchronous reset in the middle of a host wait
    den_q.push_back('{1'b0, 7'h40, 16'h0});
    rsp_q.push_back('{-1, 16'h0});
    host_start(1'b0, 7'h40, 16'h0);
    tick(5);
    #2;
    reset = 1'b1;
    #1;
    check_quiet("async_reset");
    cfg_req = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
    den_q.push_back('{1'b0, 7'h42, 16'h0});
    rsp_q.push_back('{2, 16'h0F0F});
    cfg_q.push_back('{1'b0, 16'h0F0F});
    host_start(1'b0, 7'h42, 16'h0);
    host_finish(5, "after_reset");
    tick(80);
    check("final_ack_count", n_ack, 5);
    check("final_timeout_count", n_to, 2);
    check("den_queue_empty", den_q.size(), 0);
    check("sv_queue_empty", sv_q.size(), 0);
    check("cfg_queue_empty", cfg_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
